// File: rtl/serial_frame_sched.sv
// Decimating two-channel sample framer with telemetry byte frames, feeding a UART byte transmitter.
// Optional FRAME_CKSUM_EN appends an XOR checksum byte to each sample frame.
module serial_frame_sched #(
  parameter int unsigned DECIM = 2
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        sample_stb,
  input  logic [31:0] chan0,
  input  logic [31:0] chan1,
  input  logic        tlm_valid,
  input  logic [7:0]  tlm_data,
  output logic        tlm_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        ovr_clr,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] overrun_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 4;
`ifdef FRAME_CKSUM_EN
  localparam int unsigned SMP_LAST = 10;
`else
  localparam int unsigned SMP_LAST = 9;
`endif

  typedef enum logic [1:0] {IDLE, SMP, TLM} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [63:0]        frame, frame_n;
  logic [6:0]         tlm_low, tlm_low_n;
  logic [7:0]         tx_data_n;
  logic               tx_valid_n;
  logic [CNT_W-1:0]   dcnt;
  logic [63:0]        hold;
  logic               pending;
  logic               capture;
  logic               consume_c;
  logic               ovr_evt;

  // Header carries the four bit-7s of a channel; data bytes carry the low seven bits.
  function automatic logic [7:0] smp_byte(input logic [63:0] f, input logic [IDX_W-1:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = {4'b1000, f[31], f[23], f[15], f[7]};
      4'd1:    b = {1'b0, f[6:0]};
      4'd2:    b = {1'b0, f[14:8]};
      4'd3:    b = {1'b0, f[22:16]};
      4'd4:    b = {1'b0, f[30:24]};
      4'd5:    b = {4'b0100, f[63], f[55], f[47], f[39]};
      4'd6:    b = {1'b0, f[38:32]};
      4'd7:    b = {1'b0, f[46:40]};
      4'd8:    b = {1'b0, f[54:48]};
      4'd9:    b = {1'b0, f[62:56]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [63:0] f, input logic [IDX_W-1:0] i);
    logic [7:0] b;
    b = smp_byte(f, i);
`ifdef FRAME_CKSUM_EN
    if (i == IDX_W'(SMP_LAST)) begin
      logic [7:0] t;
      b = 8'h00;
      for (int k = 0; k < 10; k++) begin
        t = smp_byte(f, IDX_W'(k));
        b = b ^ {1'b0, t[6:0]};
      end
    end
`endif
    return b;
  endfunction

  assign capture   = sample_stb && (dcnt == CNT_W'(DECIM - 1));
  assign consume_c = (state == IDLE) && pending;
  assign ovr_evt   = capture && pending && !consume_c;
  assign busy      = (state != IDLE);
  assign tlm_ready = !rst && (state == IDLE) && !pending;

  // Decimation, capture hold register and overrun bookkeeping.
  always_ff @(posedge sclk) begin
    if (rst) begin
      dcnt        <= '0;
      hold        <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (sample_stb) dcnt <= capture ? '0 : dcnt + CNT_W'(1);
      if (capture) hold <= {chan1, chan0};
      if (capture)        pending <= 1'b1;
      else if (consume_c) pending <= 1'b0;
      if (ovr_evt) begin
        overrun     <= 1'b1;
        overrun_cnt <= ovr_clr ? 16'd1 :
                       (overrun_cnt == 16'hFFFF) ? overrun_cnt : overrun_cnt + 16'd1;
      end else if (ovr_clr) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      frame    <= '0;
      tlm_low  <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      frame    <= frame_n;
      tlm_low  <= tlm_low_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
    end
  end

  // Frame sequencing: sample frames first, next byte presented on the accepting edge.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    frame_n    = frame;
    tlm_low_n  = tlm_low;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    case (state)
      IDLE: begin
        tx_valid_n = 1'b0;
        if (pending) begin
          frame_n    = hold;
          idx_n      = '0;
          tx_data_n  = frame_byte(hold, IDX_W'(0));
          tx_valid_n = 1'b1;
          state_n    = SMP;
        end else if (tlm_valid) begin
          tlm_low_n  = tlm_data[6:0];
          idx_n      = '0;
          tx_data_n  = 8'hC0 | {7'b0, tlm_data[7]};
          tx_valid_n = 1'b1;
          state_n    = TLM;
        end
      end
      SMP: begin
        if (tx_ready) begin
          if (idx == IDX_W'(SMP_LAST)) begin
            tx_valid_n = 1'b0;
            state_n    = IDLE;
          end else begin
            idx_n     = idx + IDX_W'(1);
            tx_data_n = frame_byte(frame, idx + IDX_W'(1));
          end
        end
      end
      TLM: begin
        if (tx_ready) begin
          if (idx == IDX_W'(1)) begin
            tx_valid_n = 1'b0;
            state_n    = IDLE;
          end else begin
            idx_n     = IDX_W'(1);
            tx_data_n = {1'b0, tlm_low};
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_sched.sv
// Randomized self-checking bench for serial_frame_sched against a byte-list reference model.
module tb_serial_frame_sched;

  localparam int unsigned TB_DECIM = 2;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_stb = 1'b0;
  logic [31:0] chan0 = '0;
  logic [31:0] chan1 = '0;
  logic        tlm_valid = 1'b0;
  logic [7:0]  tlm_data = '0;
  logic        tlm_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        busy;
  logic        overrun;
  logic [15:0] overrun_cnt;

  logic        s2_stb = 1'b0;
  logic        s2_tlm_ready;
  logic [7:0]  s2_tx_data;
  logic        s2_tx_valid;
  logic        s2_busy;
  logic        s2_overrun;
  logic [15:0] s2_overrun_cnt;
  logic [31:0] s2_zero = '0;
  logic [7:0]  s2_zero8 = '0;
  logic        s2_low = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mon_q[$];
  logic [7:0] exp_q[$];

  always #5 sclk = ~sclk;

  serial_frame_sched #(.DECIM(TB_DECIM)) dut (
    .sclk(sclk), .rst(rst), .sample_stb(sample_stb), .chan0(chan0), .chan1(chan1),
    .tlm_valid(tlm_valid), .tlm_data(tlm_data), .tlm_ready(tlm_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .ovr_clr(ovr_clr),
    .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  serial_frame_sched #(.DECIM(1)) dut_sat (
    .sclk(sclk), .rst(rst), .sample_stb(s2_stb), .chan0(s2_zero), .chan1(s2_zero),
    .tlm_valid(s2_low), .tlm_data(s2_zero8), .tlm_ready(s2_tlm_ready),
    .tx_data(s2_tx_data), .tx_valid(s2_tx_valid), .tx_ready(s2_low), .ovr_clr(s2_low),
    .busy(s2_busy), .overrun(s2_overrun), .overrun_cnt(s2_overrun_cnt)
  );

  // Inputs change only #1 after a rising edge, so the falling edge sees what the next edge will.
  always @(negedge sclk) if (!rst && tx_valid && tx_ready) mon_q.push_back(tx_data);

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  function automatic void add_smp(input logic [31:0] c0, input logic [31:0] c1);
    logic [31:0] ch[2];
    logic [7:0]  b;
    logic [6:0]  x;
    ch[0] = c0;
    ch[1] = c1;
    x = '0;
    for (int c = 0; c < 2; c++) begin
      b = (c == 0) ? 8'h80 : 8'h40;
      for (int k = 0; k < 4; k++) b[k] = ch[c][8*k+7];
      exp_q.push_back(b);
      x = x ^ b[6:0];
      for (int k = 0; k < 4; k++) begin
        b = {1'b0, ch[c][8*k +: 7]};
        exp_q.push_back(b);
        x = x ^ b[6:0];
      end
    end
`ifdef FRAME_CKSUM_EN
    exp_q.push_back({1'b0, x});
`endif
  endfunction

  function automatic void add_tlm(input logic [7:0] d);
    exp_q.push_back(8'hC0 | {7'b0, d[7]});
    exp_q.push_back({1'b0, d[6:0]});
  endfunction

  task automatic capture(input logic [31:0] c0, input logic [31:0] c1);
    chan0 = c0;
    chan1 = c1;
    repeat (TB_DECIM) begin
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
    end
  endtask

  task automatic run_out(input int budget, input bit rnd, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (mon_q.size() >= exp_q.size() && !busy) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tlm_valid = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tx: valid=%b data=%02h busy=%b want 0/00/0", tx_valid, tx_data, busy);
    end
    n_cmp++;
    if (overrun !== 1'b0 || overrun_cnt !== 16'd0 || tlm_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovr: ovr=%b cnt=%0d tlm_ready=%b want 0/0/0", overrun, overrun_cnt, tlm_ready);
    end
    tlm_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (tlm_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_tlm_ready: got %b want 1", tlm_ready);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_example();
    bit done;
    tx_ready = 1'b1;
    add_smp(32'h8A0B0C0D, 32'h00000080);
    capture(32'h8A0B0C0D, 32'h00000080);
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL first_latency_early: tx_valid=%b want 0", tx_valid);
    end
    tick();
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h88) begin
      n_err++;
      $display("FAIL first_byte: valid=%b data=%02h want 1/88", tx_valid, tx_data);
    end
    run_out(100, 1'b0, done);
    n_cmp++;
    if (!done || mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL example_len: got %0d bytes want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL example_byte%0d: got %02h want %02h", i, mon_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL example_gap: tx_valid=%b want 0", tx_valid);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit done;
    logic [31:0] c0, c1;
    c0 = $urandom;
    c1 = $urandom;
    tx_ready = 1'b1;
    add_smp(c0, c1);
    capture(c0, c1);
    for (int i = 0; i < 50 && mon_q.size() < 3; i++) tick();
    tx_ready = 1'b0;
    repeat (5) begin
      tick();
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[mon_q.size()]) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b data=%02h want 1/%02h", tx_valid, tx_data, exp_q[mon_q.size()]);
      end
    end
    run_out(100, 1'b0, done);
    n_cmp++;
    if (!done || mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL stall_len: got %0d bytes want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stall_byte%0d: got %02h want %02h", i, mon_q[i], exp_q[i]);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit done;
    bit all_done;
    logic [31:0] c0, c1;
    logic [7:0] d;
    all_done = 1'b1;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = 8'($urandom);
        add_tlm(d);
        tlm_data = d;
        tlm_valid = 1'b1;
        n_cmp++;
        if (tlm_ready !== 1'b1) begin
          n_err++;
          $display("FAIL rnd_tlm_ready: got %b want 1", tlm_ready);
        end
        tick();
        tlm_valid = 1'b0;
      end else begin
        c0 = $urandom;
        c1 = $urandom;
        add_smp(c0, c1);
        capture(c0, c1);
      end
      run_out(500, 1'b1, done);
      all_done = all_done && done;
    end
    n_cmp++;
    if (!all_done || mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rnd_len: got %0d bytes want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rnd_byte%0d: got %02h want %02h", i, mon_q[i], exp_q[i]);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overrun();
    bit done;
    logic [31:0] c[5][2];
    for (int i = 0; i < 5; i++) begin
      c[i][0] = $urandom;
      c[i][1] = $urandom;
    end
    tx_ready = 1'b0;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    // First capture starts a frame, second waits, third replaces the second.
    for (int i = 0; i < 3; i++) capture(c[i][0], c[i][1]);
    n_cmp++;
    if (overrun !== 1'b1 || overrun_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL ovr_three: ovr=%b cnt=%0d want 1/1", overrun, overrun_cnt);
    end
    capture(c[3][0], c[3][1]);
    n_cmp++;
    if (overrun_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL ovr_four: cnt=%0d want 2", overrun_cnt);
    end
    chan0 = c[4][0];
    chan1 = c[4][1];
    sample_stb = 1'b1;
    tick();
    ovr_clr = 1'b1;
    tick();
    sample_stb = 1'b0;
    ovr_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1 || overrun_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL ovr_clr_race: ovr=%b cnt=%0d want 1/1", overrun, overrun_cnt);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || overrun_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL ovr_clear: ovr=%b cnt=%0d want 0/0", overrun, overrun_cnt);
    end
    add_smp(c[0][0], c[0][1]);
    add_smp(c[4][0], c[4][1]);
    run_out(300, 1'b0, done);
    n_cmp++;
    if (!done || mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL ovr_len: got %0d bytes want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ovr_byte%0d: got %02h want %02h", i, mon_q[i], exp_q[i]);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_tlm_priority();
    bit done;
    int acc;
    logic [31:0] a0, a1, b0, b1;
    a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
    tx_ready = 1'b0;
    add_smp(a0, a1);
    add_smp(b0, b1);
    add_tlm(8'hA5);
    capture(a0, a1);
    capture(b0, b1);
    tlm_data = 8'hA5;
    tlm_valid = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (tlm_ready !== 1'b0) begin
      n_err++;
      $display("FAIL tlm_blocked: tlm_ready=%b want 0", tlm_ready);
    end
    tx_ready = 1'b1;
    acc = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (tlm_valid && tlm_ready) begin
        acc++;
        tick();
        tlm_valid = 1'b0;
      end else begin
        tick();
      end
      if (mon_q.size() >= exp_q.size() && !busy) done = 1'b1;
    end
    n_cmp++;
    if (acc != 1) begin
      n_err++;
      $display("FAIL tlm_accepts: got %0d want 1", acc);
    end
    n_cmp++;
    if (!done || mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL prio_len: got %0d bytes want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL prio_byte%0d: got %02h want %02h", i, mon_q[i], exp_q[i]);
      end
    end
    tlm_valid = 1'b0;
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit done;
    tx_ready = 1'b1;
    capture(32'h8A0B0C0D, 32'h00000080);
    for (int i = 0; i < 50 && mon_q.size() < 4; i++) tick();
    tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b busy=%b want 0/0", tx_valid, busy);
    end
    mon_q.delete();
    exp_q.delete();
    add_smp(32'h8A0B0C0D, 32'h00000080);
    capture(32'h8A0B0C0D, 32'h00000080);
    run_out(100, 1'b0, done);
    n_cmp++;
    if (!done || mon_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL restart_len: got %0d bytes want %0d", mon_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (mon_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL restart_byte%0d: got %02h want %02h", i, mon_q[i], exp_q[i]);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    int n;
    int want;
    s2_stb = 1'b1;
    n = 100;
    repeat (n) tick();
    // Every strobe captures; the first two are absorbed by the pending slot and the frame.
    want = n - 2;
    n_cmp++;
    if (s2_overrun_cnt !== 16'(want)) begin
      n_err++;
      $display("FAIL sat_mid: cnt=%0d want %0d", s2_overrun_cnt, want);
    end
    n_cmp++;
    if (s2_tx_valid !== 1'b1 || s2_busy !== 1'b1 || s2_tx_data !== 8'h80 || s2_tlm_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sat_stuck: v=%b b=%b d=%02h r=%b want 1/1/80/0", s2_tx_valid, s2_busy, s2_tx_data, s2_tlm_ready);
    end
    repeat (65540 - n) tick();
    n = 65540;
    want = (n - 2 > 65535) ? 65535 : n - 2;
    s2_stb = 1'b0;
    n_cmp++;
    if (s2_overrun !== 1'b1 || s2_overrun_cnt !== 16'(want)) begin
      n_err++;
      $display("FAIL sat_end: ovr=%b cnt=%0d want 1/%0d", s2_overrun, s2_overrun_cnt, want);
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_backpressure();
    test_random();
    test_overrun();
    test_tlm_priority();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
